// File: rtl/snake_game_ctrl.sv
// Snake game controller: tick-driven mover with wall/self/food checks, shift-register
// body, and a food placer that retries random candidates until one lands on a free cell.

module snake_seg_cmp (
  input  logic [6:0] seg_x,
  input  logic [6:0] seg_y,
  input  logic       live_a,
  input  logic       live_b,
  input  logic [6:0] a_x,
  input  logic [6:0] a_y,
  input  logic [6:0] b_x,
  input  logic [6:0] b_y,
  output logic       hit_a,
  output logic       hit_b
);
  assign hit_a = live_a && (seg_x == a_x) && (seg_y == a_y);
  assign hit_b = live_b && (seg_x == b_x) && (seg_y == b_y);
endmodule

module snake_game_ctrl #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MAX_LEN = 16,
  parameter int START_X = 20,
  parameter int START_Y = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] direction,
  input  logic [6:0] randX,
  input  logic [6:0] randY,
  input  logic [3:0] rd_idx,
  output logic [6:0] rd_x,
  output logic [6:0] rd_y,
  output logic       rd_valid,
  output logic [6:0] food_x,
  output logic [6:0] food_y,
  output logic [4:0] length,
  output logic [7:0] score,
  output logic [1:0] state,
  output logic       game_over
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PLACE = 2'd2, S_DEAD = 2'd3} state_t;

  localparam logic signed [7:0] GW   = 8'(GRID_W);
  localparam logic signed [7:0] GH   = 8'(GRID_H);
  localparam logic [4:0]        MAXL = 5'(MAX_LEN);
  localparam logic [3:0]        H_DOWN = 4'b1000;

  function automatic logic [MAX_LEN-1:0][6:0] init_seg(input int base, input int step);
    logic [MAX_LEN-1:0][6:0] r;
    for (int i = 0; i < MAX_LEN; i++) r[i] = (i < 3) ? 7'(base - step * i) : 7'd0;
    return r;
  endfunction

  localparam logic [MAX_LEN-1:0][6:0] INIT_X = init_seg(START_X, 0);
  localparam logic [MAX_LEN-1:0][6:0] INIT_Y = init_seg(START_Y, 1);

  state_t                  st, st_nxt;
  logic [3:0]              heading, hd_upd;
  logic [MAX_LEN-1:0][6:0] seg_x, seg_y;
  logic [6:0]              fx, fy;
  logic [4:0]              len;
  logic [7:0]              scr;
  logic signed [7:0]       nx, ny;
  logic                    dir_ok, wall, self_hit, food_hit, cand_ok, move, restart;
  logic [MAX_LEN-1:0]      hit_nh, hit_cand, live_nh, live_body;

  // Opposite heading is the bit-reverse of the one-hot code (up<->down, right<->left).
  assign dir_ok = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0)
               && (direction != {heading[0], heading[1], heading[2], heading[3]});
  assign hd_upd = dir_ok ? direction : heading;

  assign nx = $signed({1'b0, seg_x[0]}) + (hd_upd[1] ? 8'sd1 : hd_upd[2] ? -8'sd1 : 8'sd0);
  assign ny = $signed({1'b0, seg_y[0]}) + (hd_upd[3] ? 8'sd1 : hd_upd[0] ? -8'sd1 : 8'sd0);

  // Tail (index len-1) is vacated by the move, so it is excluded from the head check.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    assign live_body[i] = 5'(i) < len;
    assign live_nh[i]   = 5'(i + 1) < len;
    snake_seg_cmp u_cmp (
      .seg_x (seg_x[i]),    .seg_y (seg_y[i]),
      .live_a(live_nh[i]),  .live_b(live_body[i]),
      .a_x   (nx[6:0]),     .a_y   (ny[6:0]),
      .b_x   (randX),       .b_y   (randY),
      .hit_a (hit_nh[i]),   .hit_b (hit_cand[i])
    );
  end

  assign wall     = (nx < 8'sd0) || (nx >= GW) || (ny < 8'sd0) || (ny >= GH);
  assign self_hit = |hit_nh;
  assign food_hit = (nx[6:0] == fx) && (ny[6:0] == fy);
  assign move     = (st == S_RUN) && tick && !wall && !self_hit;
  assign cand_ok  = (randX < 7'(GRID_W)) && (randY < 7'(GRID_H)) && !(|hit_cand);
  assign restart  = (st == S_DEAD) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (start) st_nxt = S_RUN;
      S_RUN:   if (tick) begin
                 if (wall || self_hit) st_nxt = S_DEAD;
                 else if (food_hit)    st_nxt = S_PLACE;
               end
      S_PLACE: if (cand_ok) st_nxt = S_RUN;
      S_DEAD:  if (start) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      heading <= H_DOWN;
      len     <= 5'd3;
      scr     <= 8'd0;
      seg_x   <= INIT_X;
      seg_y   <= INIT_Y;
      fx      <= 7'd30;
      fy      <= 7'd20;
    end else if (restart) begin
      heading <= H_DOWN;
      len     <= 5'd3;
      scr     <= 8'd0;
      seg_x   <= INIT_X;
      seg_y   <= INIT_Y;
      fx      <= 7'd30;
      fy      <= 7'd20;
    end else begin
      if (st == S_RUN && tick) heading <= hd_upd;
      if (move) begin
        seg_x <= {seg_x[MAX_LEN-2:0], nx[6:0]};
        seg_y <= {seg_y[MAX_LEN-2:0], ny[6:0]};
        // Growth keeps the old tail: it shifts into slot len, which becomes live.
        if (food_hit) begin
          if (len < MAXL)    len <= len + 5'd1;
          if (scr != 8'hFF)  scr <= scr + 8'd1;
        end
      end
      if (st == S_PLACE && cand_ok) begin
        fx <= randX;
        fy <= randY;
      end
    end
  end

  assign rd_valid  = {1'b0, rd_idx} < len;
  assign rd_x      = rd_valid ? seg_x[rd_idx] : 7'd0;
  assign rd_y      = rd_valid ? seg_y[rd_idx] : 7'd0;
  assign food_x    = fx;
  assign food_y    = fy;
  assign length    = len;
  assign score     = scr;
  assign state     = st;
  assign game_over = (st == S_DEAD);
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: vector table for reset/heading rules, then
// hand sequences for wall death, eating/placement, tail move, self death, reset in PLACE.
`timescale 1ns/1ps
module tb_snake_game_ctrl;
  logic       clk = 1'b0;
  logic       rst, tick, start;
  logic [3:0] direction, rd_idx;
  logic [6:0] randX, randY, rd_x, rd_y, food_x, food_y;
  logic       rd_valid, game_over;
  logic [4:0] length;
  logic [7:0] score;
  logic [1:0] state;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [3:0] UP = 4'b0001, RT = 4'b0010, LF = 4'b0100, DN = 4'b1000;

  snake_game_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .direction(direction),
    .randX(randX), .randY(randY), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .food_x(food_x), .food_y(food_y), .length(length),
    .score(score), .state(state), .game_over(game_over)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       r, s, t;
    logic [3:0] d;
    logic [1:0] st;
    int         hx, hy;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_seg(input string nm, input int idx, input int ex, input int ey);
    rd_idx = 4'(idx);
    #1;
    chk({nm, ".x"}, 16'(rd_x), 16'(ex));
    chk({nm, ".y"}, 16'(rd_y), 16'(ey));
    rd_idx = 4'd0;
  endtask

  task automatic cyc(input logic s, input logic t, input logic [3:0] d);
    start = s; tick = t; direction = d;
    @(posedge clk); #1;
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic run(input int n, input logic [3:0] d);
    repeat (n) cyc(1'b0, 1'b1, d);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".state"}, 16'(state), 16'd0);
    chk({nm, ".len"}, 16'(length), 16'd3);
    chk({nm, ".score"}, 16'(score), 16'd0);
    chk({nm, ".gover"}, 16'(game_over), 16'd0);
    chk({nm, ".food_x"}, 16'(food_x), 16'd30);
    chk({nm, ".food_y"}, 16'(food_y), 16'd20);
    chk_seg({nm, ".s0"}, 0, 20, 5);
    chk_seg({nm, ".s1"}, 1, 20, 4);
    chk_seg({nm, ".s2"}, 2, 20, 3);
    rd_idx = 4'd3; #1;
    chk({nm, ".valid3"}, 16'(rd_valid), 16'd0);
    chk({nm, ".s3x"}, 16'(rd_x), 16'd0);
    rd_idx = 4'd0;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; direction = 4'd0;
    randX = 7'd45; randY = 7'd3; rd_idx = 4'd0;

    //          r  s  t  dir      st  hx  hy
    tbl[0]  = '{1, 0, 1, 4'b0000, 0, 20, 5};   // tick in IDLE ignored
    tbl[1]  = '{1, 1, 1, 4'b0000, 1, 20, 5};   // start+tick: run, no move
    tbl[2]  = '{1, 0, 1, 4'b0000, 1, 20, 6};
    tbl[3]  = '{1, 0, 0, 4'b0000, 1, 20, 6};   // no tick, no move
    tbl[4]  = '{1, 0, 1, 4'b0000, 1, 20, 7};
    tbl[5]  = '{1, 0, 1, 4'b0000, 1, 20, 8};
    tbl[6]  = '{1, 0, 1, UP,      1, 20, 9};   // reversal refused
    tbl[7]  = '{1, 0, 1, LF,      1, 19, 9};
    tbl[8]  = '{1, 0, 1, 4'b0011, 1, 18, 9};   // not one-hot: keep left
    tbl[9]  = '{1, 0, 1, RT,      1, 17, 9};   // reversal refused
    tbl[10] = '{1, 0, 1, DN,      1, 17, 10};
    tbl[11] = '{0, 0, 0, 4'b0000, 0, 20, 5};   // async reset
    tbl[12] = '{1, 0, 1, 4'b0000, 0, 20, 5};

    #25;
    chk_reset_vals("rst_hold");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r;
      cyc(tbl[i].s, tbl[i].t, tbl[i].d);
      chk($sformatf("vec%0d.state", i), 16'(state), 16'(tbl[i].st));
      chk($sformatf("vec%0d.len", i), 16'(length), 16'd3);
      chk_seg($sformatf("vec%0d.head", i), 0, tbl[i].hx, tbl[i].hy);
    end

    // Wall death at the bottom edge
    cyc(1'b1, 1'b0, 4'd0);
    run(24, DN);
    chk_seg("wall.pre", 0, 20, 29);
    chk("wall.pre_state", 16'(state), 16'd1);
    run(1, DN);
    chk("wall.state", 16'(state), 16'd3);
    chk("wall.gover", 16'(game_over), 16'd1);
    chk("wall.len", 16'(length), 16'd3);
    chk_seg("wall.s0", 0, 20, 29);
    chk_seg("wall.s2", 2, 20, 27);
    run(1, DN);
    chk("dead_tick.state", 16'(state), 16'd3);
    chk_seg("dead_tick.s0", 0, 20, 29);
    cyc(1'b1, 1'b0, 4'd0);
    chk_reset_vals("restart");

    // Eat food at (30,20), then placement with two rejected candidates
    cyc(1'b1, 1'b0, 4'd0);
    run(15, DN);
    chk_seg("eat.turn", 0, 20, 20);
    run(9, RT);
    chk("eat.pre_state", 16'(state), 16'd1);
    run(1, RT);
    chk("eat.state", 16'(state), 16'd2);
    chk("eat.len", 16'(length), 16'd4);
    chk("eat.score", 16'(score), 16'd1);
    chk_seg("eat.s0", 0, 30, 20);
    chk_seg("eat.s3", 3, 27, 20);
    randX = 7'd45; randY = 7'd3;
    cyc(1'b0, 1'b1, RT);
    chk("place.off_grid", 16'(state), 16'd2);
    chk_seg("place.tick_ignored", 0, 30, 20);
    randX = 7'd29; randY = 7'd20;
    cyc(1'b0, 1'b0, 4'd0);
    chk("place.on_body", 16'(state), 16'd2);
    chk("place.food_kept", 16'(food_x), 16'd30);
    randX = 7'd10; randY = 7'd10;
    cyc(1'b0, 1'b0, 4'd0);
    chk("place.accept_state", 16'(state), 16'd1);
    chk("place.food_x", 16'(food_x), 16'd10);
    chk("place.food_y", 16'(food_y), 16'd10);

    // Move into the vacated tail of a length-4 loop
    run(1, UP);
    run(1, LF);
    run(1, DN);
    chk("tail.state", 16'(state), 16'd1);
    chk("tail.len", 16'(length), 16'd4);
    chk_seg("tail.s0", 0, 29, 20);
    chk_seg("tail.s3", 3, 30, 20);

    // Grow to 5, then turn back into segment 3
    run(19, LF);
    chk_seg("grow.turn", 0, 10, 20);
    run(10, UP);
    chk("grow.state", 16'(state), 16'd2);
    chk("grow.len", 16'(length), 16'd5);
    chk("grow.score", 16'(score), 16'd2);
    randX = 7'd0; randY = 7'd0;
    cyc(1'b0, 1'b0, 4'd0);
    chk("grow.place", 16'(state), 16'd1);
    run(1, RT);
    run(1, DN);
    run(1, LF);
    chk("self.state", 16'(state), 16'd3);
    chk("self.gover", 16'(game_over), 16'd1);
    chk_seg("self.s0", 0, 11, 11);
    chk_seg("self.s3", 3, 10, 11);
    chk_seg("self.s4", 4, 10, 12);

    // Reset pulse while in PLACE
    cyc(1'b1, 1'b0, 4'd0);
    chk("rst_place.idle", 16'(state), 16'd0);
    cyc(1'b1, 1'b0, 4'd0);
    run(15, DN);
    run(10, RT);
    chk("rst_place.in_place", 16'(state), 16'd2);
    randX = 7'd45; randY = 7'd3;
    cyc(1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    #1;
    chk("rst_place.async", 16'(state), 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    randX = 7'd10; randY = 7'd10;
    chk_reset_vals("rst_place");
    cyc(1'b0, 1'b1, RT);
    chk("rst_place.after_state", 16'(state), 16'd0);
    chk("rst_place.after_food", 16'(food_x), 16'd30);
    chk_seg("rst_place.after_head", 0, 20, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
